// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to instruction memory and
// loads the IF/ID pipeline register, honouring hazard stalls and EX-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_en,
    input  logic        i_if_id_en,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_raddr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic [31:0] o_if_id_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] hold_buf;
    logic [31:0] hold_next;
    logic [31:0] redirect;
    logic [31:0] deliver_inst;
    logic        deliver;
    logic        req_raw;
    logic        go;

    assign go       = i_pc_en & i_if_id_en & ~i_flush;
    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = i_redirect_pc & 32'hFFFF_FFFC;
    // Reset suppresses any request so the memory never sees a pre-reset fetch.
    assign o_imem_req = req_raw & ~i_rst;

    // Next-state, PC update, hold-buffer capture and memory request generation.
    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        hold_next    = hold_buf;
        req_raw      = 1'b0;
        o_imem_raddr = pc_q;
        deliver      = 1'b0;
        deliver_inst = hold_buf;
        case (state)
            S_REQ: begin
                req_raw = ~i_flush;
                if (i_flush) begin
                    pc_next = redirect;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_valid && i_flush) begin
                    pc_next    = redirect;
                    state_next = S_REQ;
                end else if (i_imem_valid && go) begin
                    // Chain the next request in the delivery cycle for 1 instr/cycle.
                    deliver      = 1'b1;
                    deliver_inst = i_imem_rdata;
                    pc_next      = pc_plus4;
                    req_raw      = 1'b1;
                    o_imem_raddr = pc_plus4;
                end else if (i_imem_valid) begin
                    hold_next  = i_imem_rdata;
                    state_next = S_HOLD;
                end else if (i_flush) begin
                    pc_next    = redirect;
                    state_next = S_KILL;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_KILL: begin
                if (i_flush) begin
                    pc_next = redirect;
                end else begin
                    pc_next = pc_q;
                end
                if (i_imem_valid) begin
                    state_next = S_REQ;
                end else begin
                    state_next = S_KILL;
                end
            end
            S_HOLD: begin
                if (i_flush) begin
                    pc_next    = redirect;
                    state_next = S_REQ;
                end else if (go) begin
                    deliver    = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = S_REQ;
                end else begin
                    state_next = S_HOLD;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // State, PC and hold-buffer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_REQ;
            pc_q     <= RESET_ADDR;
            hold_buf <= 32'h0000_0000;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            hold_buf <= hold_next;
        end
    end

    // IF/ID register: flush beats stall beats load; otherwise a bubble is inserted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_if_id_valid <= 1'b0;
            o_if_id_pc    <= 32'h0000_0000;
            o_if_id_pc4   <= 32'h0000_0000;
            o_if_id_inst  <= NOP_INST;
        end else if (i_flush) begin
            o_if_id_valid <= 1'b0;
            o_if_id_inst  <= NOP_INST;
        end else if (!i_if_id_en) begin
            o_if_id_valid <= o_if_id_valid;
        end else if (deliver) begin
            o_if_id_valid <= 1'b1;
            o_if_id_pc    <= pc_q;
            o_if_id_pc4   <= pc_plus4;
            o_if_id_inst  <= deliver_inst;
        end else begin
            o_if_id_valid <= 1'b0;
            o_if_id_inst  <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected request addresses
// and IF/ID deliveries; monitors compare them against the DUT on every falling edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst;
    logic        i_pc_en;
    logic        i_if_id_en;
    logic        i_flush;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_raddr;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic        o_if_id_valid;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_pc4;
    logic [31:0] o_if_id_inst;

    fetch_stage dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc_en       (i_pc_en),
        .i_if_id_en    (i_if_id_en),
        .i_flush       (i_flush),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_raddr  (o_imem_raddr),
        .i_imem_valid  (i_imem_valid),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_id_valid (o_if_id_valid),
        .o_if_id_pc    (o_if_id_pc),
        .o_if_id_pc4   (o_if_id_pc4),
        .o_if_id_inst  (o_if_id_inst)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    logic        edge_rst, edge_ife, edge_flush;
    logic        last_valid;
    logic [31:0] last_pc, last_pc4, last_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5EED_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic er(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic ei(input logic [31:0] pc);
        exp_pc.push_back(pc);
    endtask

    task automatic begin_test(input int l);
        lat   = l;
        i_rst = 1'b0;
    endtask

    task automatic end_test();
        i_rst = 1'b1;
        i_pc_en = 1'b1;
        i_if_id_en = 1'b1;
        i_flush = 1'b0;
        tick();
        check("req_left", 32'(exp_req.size()), 32'd0);
        check("ifid_left", 32'(exp_pc.size()), 32'd0);
        exp_req.delete();
        exp_pc.delete();
    endtask

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Instruction memory: fixed latency, in-order, cleared by reset
    initial begin
        i_imem_valid = 1'b0;
        i_imem_rdata = 32'h0;
        forever begin
            @(posedge i_clk);
            cyc++;
            #2;
            i_imem_valid = 1'b0;
            if (i_rst) begin
                mq_addr.delete();
                mq_due.delete();
            end else if (mq_due.size() > 0 && mq_due[0] == cyc) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            #1;
            if (o_imem_req) begin
                mq_addr.push_back(o_imem_raddr);
                mq_due.push_back(cyc + lat);
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            edge_rst   = i_rst;
            edge_ife   = i_if_id_en;
            edge_flush = i_flush;
        end
    end

    // Monitor: request addresses and IF/ID contents against the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            if (o_imem_req) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_extra: got request %h expected none", o_imem_raddr);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr", o_imem_raddr, e);
                end
            end
            if (edge_rst) begin
                check("rst_valid", {31'd0, o_if_id_valid}, 32'd0);
                check("rst_inst", o_if_id_inst, NOP);
                check("rst_pc", o_if_id_pc, 32'd0);
                check("rst_pc4", o_if_id_pc4, 32'd0);
            end else if (edge_flush) begin
                check("flush_valid", {31'd0, o_if_id_valid}, 32'd0);
                check("flush_inst", o_if_id_inst, NOP);
            end else if (!edge_ife) begin
                check("hold_valid", {31'd0, o_if_id_valid}, {31'd0, last_valid});
                check("hold_pc", o_if_id_pc, last_pc);
                check("hold_pc4", o_if_id_pc4, last_pc4);
                check("hold_inst", o_if_id_inst, last_inst);
            end else if (o_if_id_valid) begin
                if (exp_pc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ifid_extra: got pc %h expected no instruction", o_if_id_pc);
                end else begin
                    e = exp_pc.pop_front();
                    check("ifid_pc", o_if_id_pc, e);
                    check("ifid_pc4", o_if_id_pc4, e + 32'd4);
                    check("ifid_inst", o_if_id_inst, mem_word(e));
                end
            end else begin
                check("bubble_inst", o_if_id_inst, NOP);
            end
            last_valid = o_if_id_valid;
            last_pc    = o_if_id_pc;
            last_pc4   = o_if_id_pc4;
            last_inst  = o_if_id_inst;
        end
    end

    initial begin
        i_rst = 1'b1;
        i_pc_en = 1'b1;
        i_if_id_en = 1'b1;
        i_flush = 1'b0;
        i_redirect_pc = 32'h0;
        tick();

        // 1: back-to-back fetch with 1-cycle memory
        er(32'h0); er(32'h4); er(32'h8); er(32'hC); er(32'h10);
        ei(32'h0); ei(32'h4); ei(32'h8); ei(32'hC);
        begin_test(1);
        repeat (5) tick();
        end_test();

        // 2: stall while response for pc=8 arrives -> hold buffer, delivered once
        er(32'h0); er(32'h4); er(32'h8); er(32'hC); er(32'h10); er(32'h14);
        ei(32'h0); ei(32'h4); ei(32'h8); ei(32'hC); ei(32'h10);
        begin_test(1);
        repeat (3) tick();
        i_pc_en = 1'b0; i_if_id_en = 1'b0;
        repeat (3) tick();
        i_pc_en = 1'b1; i_if_id_en = 1'b1;
        repeat (4) tick();
        end_test();

        // 3: flush in WAIT with 2-cycle memory -> KILL discards response
        er(32'h0); er(32'h100); er(32'h104); er(32'h108);
        ei(32'h100); ei(32'h104);
        begin_test(2);
        tick();
        i_flush = 1'b1; i_redirect_pc = 32'h0000_0103;
        tick();
        i_flush = 1'b0;
        repeat (6) tick();
        end_test();

        // 4: flush together with IF/ID stall -> flush wins
        er(32'h0); er(32'h4); er(32'h200); er(32'h204); er(32'h208);
        ei(32'h0); ei(32'h200); ei(32'h204);
        begin_test(1);
        repeat (2) tick();
        i_flush = 1'b1; i_if_id_en = 1'b0; i_redirect_pc = 32'h200;
        tick();
        i_flush = 1'b0; i_if_id_en = 1'b1;
        repeat (3) tick();
        end_test();

        // 5: 3-cycle memory -> bubbles between instructions
        er(32'h0); er(32'h4); er(32'h8); er(32'hC); er(32'h10);
        ei(32'h0); ei(32'h4); ei(32'h8); ei(32'hC);
        begin_test(3);
        repeat (13) tick();
        end_test();

        // 6: reset while in WAIT -> restart at RESET_ADDR
        er(32'h0); er(32'h4); er(32'h8); er(32'h0); er(32'h4); er(32'h8);
        ei(32'h0); ei(32'h4); ei(32'h0); ei(32'h4);
        begin_test(1);
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (3) tick();
        end_test();

        // 7: PC wraps from FFFF_FFFC to 0
        er(32'h0); er(32'hFFFF_FFF8); er(32'hFFFF_FFFC); er(32'h0); er(32'h4);
        ei(32'hFFFF_FFF8); ei(32'hFFFF_FFFC); ei(32'h0);
        begin_test(1);
        tick();
        i_flush = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        i_flush = 1'b0;
        repeat (4) tick();
        end_test();

        // 8: PC stall only -> HOLD, then flush drops the held word
        er(32'h0); er(32'h4); er(32'h300); er(32'h304);
        ei(32'h0); ei(32'h300);
        begin_test(1);
        repeat (2) tick();
        i_pc_en = 1'b0;
        tick();
        i_pc_en = 1'b1; i_flush = 1'b1; i_redirect_pc = 32'h300;
        tick();
        i_flush = 1'b0;
        repeat (2) tick();
        end_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
